// File: rtl/ulpb_member_node.sv
// ulpb_member_node: one member of a ULPB ring bus.
// The node requests the bus, wins or loses arbitration by its ring position, and sends
// one address+data message. Otherwise it receives messages addressed to it and filters them.
// While it is not transmitting, it forwards upstream DIN to DOUT.
// The bus clock CLKI is oversampled by CLK_IN and is never used as a clock.
// Optional feature: define ULPB_BROADCAST_EN so that the all-ones address is also accepted.
module ulpb_member_node #(
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] NODE_ADDR   = 4'h3,
  parameter int                    IDLE_CYCLES = 64
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  CLKI,
  input  logic                  DIN,
  output logic                  DOUT,
  input  logic                  TX_REQ,
  input  logic [ADDR_WIDTH-1:0] TX_ADDR,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_DONE,
  output logic                  TX_FAIL,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  RX_ERR
);

  localparam int MSG_BITS = ADDR_WIDTH + DATA_WIDTH;
  localparam int SLOT_W   = $clog2(2 * MSG_BITS + 3);
  localparam int CNT_W    = $clog2(MSG_BITS + 2);
  localparam int IDLE_W   = $clog2(IDLE_CYCLES + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_ARB  = 3'd2;
  localparam logic [2:0] ST_TX   = 3'd3;
  localparam logic [2:0] ST_RX   = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  // Half-slot indices, counted in CLKI falls after arbitration is won
  localparam logic [SLOT_W-1:0] SLOT_EOM_A = SLOT_W'(2 * MSG_BITS);
  localparam logic [SLOT_W-1:0] SLOT_END   = SLOT_W'(2 * MSG_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_ADDR   = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MSG    = CNT_W'(MSG_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(MSG_BITS + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_CYCLES);

  // ---------------------------------------------------------------------------
  // Input synchronisation: bit 0 = CLKI, bit 1 = DIN
  // ---------------------------------------------------------------------------
  logic [1:0] pin_in;
  logic [1:0] pin_sync;
  logic [1:0] pin_hist;

  assign pin_in = {DIN, CLKI};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    logic hist_reg;

    // Two-flop synchroniser plus a history flop; reset to the idle-high bus level
    always_ff @(posedge CLK_IN) begin
      if (RESET) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
        hist_reg <= 1'b1;
      end else begin
        meta_reg <= pin_in[gi];
        sync_reg <= meta_reg;
        hist_reg <= sync_reg;
      end
    end

    assign pin_sync[gi] = sync_reg;
    assign pin_hist[gi] = hist_reg;
  end

  // The history stage serves as the synchronised level, so DIN is aligned with the edge flags
  logic clki_s;
  logic din_s;
  assign clki_s = pin_hist[0];
  assign din_s  = pin_hist[1];

  logic clki_rise_reg;
  logic clki_fall_reg;

  // Register the CLKI edge flags so that they line up with clki_s and din_s
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      clki_rise_reg <= 1'b0;
      clki_fall_reg <= 1'b0;
    end else begin
      clki_rise_reg <= pin_sync[0] & ~pin_hist[0];
      clki_fall_reg <= ~pin_sync[0] & pin_hist[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Bus idle detection
  // ---------------------------------------------------------------------------
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              idle_reached;

  assign idle_reached = (idle_cnt_reg == IDLE_MAX);

  // Count CLK_IN cycles with CLKI high, saturating; any low level restarts the count
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      idle_cnt_reg <= '0;
    end else if (!clki_s) begin
      idle_cnt_reg <= '0;
    end else if (!idle_reached) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol state machine
  // ---------------------------------------------------------------------------
  logic [2:0]            state_reg,    state_next;
  logic                  dout_reg,     dout_next;
  logic [MSG_BITS-1:0]   tx_word_reg,  tx_word_next;
  logic [SLOT_W-1:0]     slot_reg,     slot_next;
  logic [ADDR_WIDTH-1:0] rx_addr_reg,  rx_addr_next;
  logic [DATA_WIDTH-1:0] rx_sh_reg,    rx_sh_next;
  logic [CNT_W-1:0]      bit_cnt_reg,  bit_cnt_next;
  logic                  half_b_reg,   half_b_next;
  logic                  samp_a_reg,   samp_a_next;
  logic                  tx_done_reg,  tx_done_next;
  logic                  tx_fail_reg,  tx_fail_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic                  rx_err_reg,   rx_err_next;
  logic [DATA_WIDTH-1:0] rx_data_reg,  rx_data_next;
  logic                  addr_match;

  // Decide whether the received address is one that this node accepts
  always_comb begin
    addr_match = (rx_addr_reg == NODE_ADDR);
`ifdef ULPB_BROADCAST_EN
    if (&rx_addr_reg) begin
      addr_match = 1'b1;
    end
`endif
  end

  // Next-state, bus drive and receive-filter logic
  always_comb begin
    state_next    = state_reg;
    dout_next     = din_s;
    tx_word_next  = tx_word_reg;
    slot_next     = slot_reg;
    rx_addr_next  = rx_addr_reg;
    rx_sh_next    = rx_sh_reg;
    bit_cnt_next  = bit_cnt_reg;
    half_b_next   = half_b_reg;
    samp_a_next   = samp_a_reg;
    tx_done_next  = 1'b0;
    tx_fail_next  = 1'b0;
    rx_valid_next = 1'b0;
    rx_err_next   = 1'b0;
    rx_data_next  = rx_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (clki_fall_reg) begin
          // Another node started a message, so join as a non-requester
          state_next = ST_ARB;
        end else if (TX_REQ && idle_reached) begin
          tx_word_next = {TX_ADDR, TX_DATA};
          dout_next    = 1'b0;
          state_next   = ST_REQ;
        end
      end

      ST_REQ: begin
        dout_next = 1'b0;
        if (clki_rise_reg) begin
          if (!din_s) begin
            // An upstream node also requested and owns the bus. This rise is the one ARB
            // would wait for, so go straight to receiving and stay aligned with the sender.
            tx_fail_next = 1'b1;
            dout_next    = din_s;
            state_next   = ST_RX;
            bit_cnt_next = '0;
            half_b_next  = 1'b0;
            rx_addr_next = '0;
            rx_sh_next   = '0;
          end else begin
            slot_next  = '0;
            state_next = ST_TX;
          end
        end
      end

      ST_ARB: begin
        if (clki_rise_reg) begin
          state_next   = ST_RX;
          bit_cnt_next = '0;
          half_b_next  = 1'b0;
          rx_addr_next = '0;
          rx_sh_next   = '0;
        end
      end

      ST_TX: begin
        dout_next = dout_reg;
        if (clki_fall_reg) begin
          if (slot_reg < SLOT_EOM_A) begin
            // Each bit is driven in both half-slots; move to the next bit after half-slot B
            dout_next = tx_word_reg[MSG_BITS-1];
            if (slot_reg[0]) begin
              tx_word_next = {tx_word_reg[MSG_BITS-2:0], 1'b0};
            end
          end else if (slot_reg == SLOT_EOM_A) begin
            dout_next = 1'b1;
          end else begin
            dout_next = 1'b0;
          end
          if (slot_reg != SLOT_END) begin
            slot_next = slot_reg + 1'b1;
          end
        end
        if (clki_rise_reg && (slot_reg == SLOT_END)) begin
          // Downstream has sampled EOM half-slot B, so release the bus
          tx_done_next = 1'b1;
          dout_next    = din_s;
          state_next   = ST_WAIT;
        end
      end

      ST_RX: begin
        if (clki_rise_reg) begin
          if (!half_b_reg) begin
            samp_a_next = din_s;
            half_b_next = 1'b1;
          end else begin
            half_b_next = 1'b0;
            if (samp_a_reg == din_s) begin
              if (bit_cnt_reg < CNT_ADDR) begin
                rx_addr_next = {rx_addr_reg[ADDR_WIDTH-2:0], din_s};
              end else if (bit_cnt_reg < CNT_MSG) begin
                rx_sh_next = {rx_sh_reg[DATA_WIDTH-2:0], din_s};
              end
              if (bit_cnt_reg != CNT_SAT) begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end else begin
              // Unequal half-slots mark end of message
              state_next = ST_WAIT;
              if ((bit_cnt_reg >= CNT_ADDR) && addr_match) begin
                if (bit_cnt_reg == CNT_MSG) begin
                  rx_data_next  = rx_sh_reg;
                  rx_valid_next = 1'b1;
                end else begin
                  rx_err_next = 1'b1;
                end
              end
            end
          end
        end
      end

      ST_WAIT: begin
        if (idle_reached) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any message in progress without pulses
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      dout_reg     <= 1'b1;
      tx_word_reg  <= '0;
      slot_reg     <= '0;
      rx_addr_reg  <= '0;
      rx_sh_reg    <= '0;
      bit_cnt_reg  <= '0;
      half_b_reg   <= 1'b0;
      samp_a_reg   <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_fail_reg  <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      rx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      dout_reg     <= dout_next;
      tx_word_reg  <= tx_word_next;
      slot_reg     <= slot_next;
      rx_addr_reg  <= rx_addr_next;
      rx_sh_reg    <= rx_sh_next;
      bit_cnt_reg  <= bit_cnt_next;
      half_b_reg   <= half_b_next;
      samp_a_reg   <= samp_a_next;
      tx_done_reg  <= tx_done_next;
      tx_fail_reg  <= tx_fail_next;
      rx_valid_reg <= rx_valid_next;
      rx_err_reg   <= rx_err_next;
      rx_data_reg  <= rx_data_next;
    end
  end

  assign DOUT     = dout_reg;
  assign TX_DONE  = tx_done_reg;
  assign TX_FAIL  = tx_fail_reg;
  assign RX_DATA  = rx_data_reg;
  assign RX_VALID = rx_valid_reg;
  assign RX_ERR   = rx_err_reg;

endmodule
